// File: rtl/regfile_read_server_pkg.sv
// Shared definitions for the register-file read server: default geometry,
// sweep FSM state encoding and the hard-wired zero register index.
package regfile_read_server_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DEPTH_DEF = 32;
    localparam int AW_DEF    = 5;
    localparam int ZERO_REG  = 0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_rsp_stage.sv
// Single output register for the two read operands with valid/ready flow control.
// Data holds while a response is pending and the consumer is not ready.
module regfile_rsp_stage
    import regfile_read_server_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_a_p0,
    input  logic [WIDTH-1:0] data_b_p0,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data_a,
    output logic [WIDTH-1:0] rsp_data_b
);

    logic             vld_p1;
    logic [WIDTH-1:0] data_a_p1;
    logic [WIDTH-1:0] data_b_p1;

    // p0 -> p1: a new accept always wins over draining the held response
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            data_a_p1 <= '0;
            data_b_p1 <= '0;
        end else if (load) begin
            vld_p1    <= 1'b1;
            data_a_p1 <= data_a_p0;
            data_b_p1 <= data_b_p0;
        end else if (rsp_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign rsp_valid  = vld_p1;
    assign rsp_data_a = data_a_p1;
    assign rsp_data_b = data_b_p1;

endmodule

// File: rtl/regfile_read_server.sv
// Register file with zeroing sweep after reset and a buffered dual read port.
// Define REGFILE_READ_BYPASS_EN to forward a same-cycle write into the read response.
module regfile_read_server
    import regfile_read_server_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW-1:0]    req_addr_a,
    input  logic [AW-1:0]    req_addr_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data_a,
    output logic [WIDTH-1:0] rsp_data_b,
    output logic             init_done
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e            state, state_nxt;
    logic [AW-1:0]     sweep_ptr, sweep_ptr_nxt;
    logic [WIDTH-1:0]  mem [1:DEPTH-1];
    logic              wr_fire;
    logic              accept;
    logic [WIDTH-1:0]  rd_a_p0;
    logic [WIDTH-1:0]  rd_b_p0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_INIT;
            sweep_ptr <= AW'(1);
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        if (state == ST_INIT) begin
            sweep_ptr_nxt = sweep_ptr + AW'(1);
            if (sweep_ptr == LAST_ADDR) begin
                sweep_ptr_nxt = ZERO_ADDR;
                state_nxt     = ST_RUN;
            end
        end
    end

    assign init_done = (state == ST_RUN);
    assign wr_fire   = (state == ST_RUN) && wr_en && (wr_addr != ZERO_ADDR);

    // Register 0 has no storage; the sweep pointer never reaches it
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state == ST_INIT) begin
                mem[sweep_ptr] <= '0;
            end else if (wr_fire) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    always_comb begin
        rd_a_p0 = '0;
        rd_b_p0 = '0;
        if (req_addr_a != ZERO_ADDR) rd_a_p0 = mem[req_addr_a];
        if (req_addr_b != ZERO_ADDR) rd_b_p0 = mem[req_addr_b];
`ifdef REGFILE_READ_BYPASS_EN
        if (wr_fire && (wr_addr == req_addr_a)) rd_a_p0 = wr_data;
        if (wr_fire && (wr_addr == req_addr_b)) rd_b_p0 = wr_data;
`endif
    end

    assign req_ready = (state == ST_RUN) && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    regfile_rsp_stage #(
        .WIDTH (WIDTH)
    ) u_rsp_stage (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (accept),
        .data_a_p0  (rd_a_p0),
        .data_b_p0  (rd_b_p0),
        .rsp_ready  (rsp_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b)
    );

endmodule

// File: tb/tb_regfile_read_server.sv
// Scoreboard bench for regfile_read_server: directed scenarios then random traffic
// against an array-based reference model of the register file and handshake.
module tb_regfile_read_server;

    localparam int W = 32;
    localparam int D = 32;
    localparam int A = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr_en;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         req_valid;
    logic         req_ready;
    logic [A-1:0] req_addr_a;
    logic [A-1:0] req_addr_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data_a;
    logic [W-1:0] rsp_data_b;
    logic         init_done;

    always #5 clk = ~clk;

    regfile_read_server #(
        .WIDTH (W),
        .DEPTH (D),
        .AW    (A)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr_a (req_addr_a),
        .req_addr_b (req_addr_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data_a (rsp_data_a),
        .rsp_data_b (rsp_data_b),
        .init_done  (init_done)
    );

    int           checks = 0;
    int           errors = 0;
    bit           chk_en = 1'b0;

    // Reference model: register contents, run flag, sweep counter, pending response
    logic [W-1:0]   model [D];
    bit             run_m;
    bit             pend_m;
    int             cnt_m;
    logic [2*W-1:0] q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_rd(input logic [A-1:0] addr);
        if (addr == 0) return '0;
`ifdef REGFILE_READ_BYPASS_EN
        if (run_m && wr_en && wr_addr == addr) return wr_data;
`endif
        return model[addr];
    endfunction

    // Inputs are already driven; check at negedge, advance model for the coming edge
    task automatic step();
        bit exp_ready;
        bit accept;
        @(negedge clk);
        exp_ready = run_m && (!pend_m || rsp_ready);
        if (chk_en) begin
            chk("init_done", 64'(init_done), 64'(run_m));
            chk("rsp_valid", 64'(rsp_valid), 64'(pend_m));
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
        end
        if (!reset_n) begin
            run_m  = 1'b0;
            pend_m = 1'b0;
            cnt_m  = 0;
            q.delete();
            for (int i = 0; i < D; i++) model[i] = '0;
        end else begin
            accept = req_valid && exp_ready;
            if (accept) q.push_back({ref_rd(req_addr_a), ref_rd(req_addr_b)});
            if (run_m && wr_en && wr_addr != 0) model[wr_addr] = wr_data;
            if (!run_m) begin
                cnt_m++;
                if (cnt_m == D - 1) run_m = 1'b1;
            end
            pend_m = accept ? 1'b1 : (rsp_ready ? 1'b0 : pend_m);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: the presented response must match the queue head; pop on transfer
    always @(negedge clk) begin
        if (chk_en && reset_n && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                chk("rsp_data", {rsp_data_a, rsp_data_b}, q[0]);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic idle();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        req_valid  = 1'b0;
        req_addr_a = '0;
        req_addr_b = '0;
        rsp_ready  = 1'b1;
    endtask

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [A-1:0] a, input logic [A-1:0] b);
        req_valid = 1'b1; req_addr_a = a; req_addr_b = b;
        step();
        req_valid = 1'b0;
    endtask

    task automatic do_reset_and_sweep();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (D - 1) step();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        @(posedge clk);
        #1;
        step();
        chk_en = 1'b1;
        step();
        reset_n = 1'b1;
        // Sweep with writes and requests pending: both must be ignored
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hA5A5_A5A5;
        req_valid = 1'b1; req_addr_a = 5'd5; req_addr_b = 5'd9;
        repeat (D - 1) step();
        idle();
        step();

        for (int i = 1; i < D; i++) do_read(A'(i), A'(i) ^ 5'h1f);
        step();

        do_write(5'd5, 32'hDEAD_BEEF);
        do_read(5'd5, 5'd0);
        step();

        do_write(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, 5'd0);
        step();

        // Back-pressure with a queued request
        rsp_ready = 1'b0;
        do_read(5'd5, 5'd3);
        req_valid = 1'b1; req_addr_a = 5'd3; req_addr_b = 5'd5;
        repeat (3) step();
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        step();

        // Same-cycle write and read of reg 7
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234_5678;
        req_valid = 1'b1; req_addr_a = 5'd7; req_addr_b = 5'd7;
        step();
        idle();
        do_read(5'd7, 5'd0);
        step();

        // Reset mid-stream with a held response
        rsp_ready = 1'b0;
        do_read(5'd5, 5'd5);
        do_reset_and_sweep();
        rsp_ready = 1'b1;
        step();
        do_read(5'd5, 5'd7);
        step();

        for (int n = 0; n < 3000; n++) begin
            reset_n    = ($urandom_range(0, 599) != 0);
            wr_en      = ($urandom_range(0, 2) == 0);
            wr_addr    = A'($urandom_range(0, 7));
            wr_data    = $urandom;
            req_valid  = ($urandom_range(0, 3) != 0);
            req_addr_a = A'($urandom_range(0, 7));
            req_addr_b = ($urandom_range(0, 3) == 0) ? req_addr_a : A'($urandom_range(0, D - 1));
            rsp_ready  = ($urandom_range(0, 3) != 0);
            step();
        end

        reset_n = 1'b1;
        idle();
        repeat (D + 2) step();
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
